// File: rtl/pool_window_sequencer.sv
// Sequencer around an external combinational 2x2 max-pool datapath.
// Buffers one IMG_H x IMG_W frame from a valid/ready pixel stream, then walks
// 2x2 windows in row-major order at STRIDE, presenting each window on pix_*,
// capturing max_pixel and emitting it on a back-pressurable valid/ready stream.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start                    begin a frame (honoured only when idle)
//   in_valid/in_ready/in_data  pixel input stream, row-major
//   pix_00..pix_11           registered window pixels to the datapath
//   max_pixel                datapath result
//   out_valid/out_ready/out_data/out_last  pooled result stream
//   busy                     not idle
//   done                     one-cycle pulse after the final output handshake
module pool_window_sequencer #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned IMG_W  = 3,
  parameter int unsigned IMG_H  = 3,
  parameter int unsigned STRIDE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [DATA_W-1:0] pix_00,
  output logic [DATA_W-1:0] pix_01,
  output logic [DATA_W-1:0] pix_10,
  output logic [DATA_W-1:0] pix_11,
  input  logic [DATA_W-1:0] max_pixel,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  localparam int unsigned OUT_W  = (IMG_W - 2) / STRIDE + 1;
  localparam int unsigned OUT_H  = (IMG_H - 2) / STRIDE + 1;
  localparam int unsigned N_PIX  = IMG_W * IMG_H;
  localparam int unsigned ADDR_W = (N_PIX > 1) ? $clog2(N_PIX) : 1;
  localparam int unsigned WC_W   = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int unsigned WR_W   = (OUT_H > 1) ? $clog2(OUT_H) : 1;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LOAD  = 3'd1;
  localparam logic [2:0] SETUP = 3'd2;
  localparam logic [2:0] ISSUE = 3'd3;
  localparam logic [2:0] EMIT  = 3'd4;

  logic [2:0]        state;
  logic [2:0]        state_nxt;
  logic [ADDR_W-1:0] load_cnt;
  logic [WC_W-1:0]   wc;
  logic [WR_W-1:0]   wr;
  logic [ADDR_W-1:0] org_addr;
  logic              last_win;
  logic              last_beat;
  logic [DATA_W-1:0] frame_buf [N_PIX];

  // Top-left buffer address of the current window.
  always_comb begin
    org_addr = ADDR_W'((32'(wr) * STRIDE) * IMG_W + 32'(wc) * STRIDE);
  end

  assign last_win  = (wr == WR_W'(OUT_H - 1)) && (wc == WC_W'(OUT_W - 1));
  assign last_beat = (load_cnt == ADDR_W'(N_PIX - 1));

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD:    if (in_valid && last_beat) state_nxt = SETUP;
      SETUP:   state_nxt = ISSUE;
      ISSUE:   state_nxt = EMIT;
      EMIT:    if (out_ready) state_nxt = last_win ? IDLE : SETUP;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Frame buffer; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (state == LOAD && in_valid) frame_buf[load_cnt] <= in_data;
  end

  // Counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      pix_00    <= '0;
      pix_01    <= '0;
      pix_10    <= '0;
      pix_11    <= '0;
      load_cnt  <= '0;
      wc        <= '0;
      wr        <= '0;
    end else begin
      // Flags track the state being entered so they line up with it.
      in_ready <= (state_nxt == LOAD);
      busy     <= (state_nxt != IDLE);
      done     <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            load_cnt <= '0;
            wc       <= '0;
            wr       <= '0;
          end
        end
        LOAD: begin
          if (in_valid) load_cnt <= load_cnt + ADDR_W'(1);
        end
        SETUP: begin
          pix_00 <= frame_buf[org_addr];
          pix_01 <= frame_buf[org_addr + ADDR_W'(1)];
          pix_10 <= frame_buf[org_addr + ADDR_W'(IMG_W)];
          pix_11 <= frame_buf[org_addr + ADDR_W'(IMG_W + 1)];
        end
        ISSUE: begin
          out_data  <= max_pixel;
          out_valid <= 1'b1;
          out_last  <= last_win;
        end
        EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (last_win) begin
              out_last <= 1'b0;
              done     <= 1'b1;
            end else if (wc == WC_W'(OUT_W - 1)) begin
              wc <= '0;
              wr <= wr + WR_W'(1);
            end else begin
              wc <= wc + WC_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/pool_window_sequencer.md
# pool_window_sequencer

Sequencing controller for the combinational 2x2 max-pool datapath (`downsample`). It accepts an IMG_H x IMG_W image as a valid/ready pixel stream into a local frame buffer. It then walks 2x2 windows in row-major order at a configurable stride, presenting each window's four pixels to the external `downsample` instance and capturing its `max_pixel`. Pooled results leave on a valid/ready stream with a last flag, so the testbench-style file-driven pooling becomes a clocked, back-pressurable pipeline stage.

## Interface
- DATA_W, 8: pixel width; also the width of the datapath ports.
- IMG_W, 3: image width in pixels; must be ≥ 2.
- IMG_H, 3: image height in pixels; must be ≥ 2.
- STRIDE, 1: window step in both dimensions; must be ≥ 1.
- Derived: OUT_W = (IMG_W-2)/STRIDE+1, OUT_H = (IMG_H-2)/STRIDE+1, N_OUT = OUT_W*OUT_H.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a frame; sampled only in IDLE.
- in_valid  in  1  input pixel valid.
- in_data  in  DATA_W  input pixel, row-major order.
- in_ready  out  1  high only in LOAD.
- pix_00, pix_01, pix_10, pix_11  out  DATA_W each  registered window pixels to `downsample`: (r,c), (r,c+1), (r+1,c), (r+1,c+1).
- max_pixel  in  DATA_W  `downsample` result.
- out_valid  out  1  pooled result valid.
- out_data  out  DATA_W  pooled result.
- out_last  out  1  qualifies the final window of the frame.
- out_ready  in  1  downstream accept.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse after the last output handshake.

## Operation
- Frame buffer: IMG_W*IMG_H entries of DATA_W. Address = row*IMG_W + col.
- FSM states: IDLE, LOAD, SETUP, ISSUE, EMIT.
- IDLE:
  - start=1 → LOAD; clear load count and window counters (wr=0, wc=0).
  - start while not in IDLE is ignored.
- LOAD:
  - in_ready=1; each in_valid&in_ready beat writes buffer[count] and increments count.
  - The beat with count = IMG_W*IMG_H-1 → SETUP.
  - Gaps in in_valid are allowed; they stall with no side effects.
- SETUP: pix_* are loaded from the buffer at window origin (wr*STRIDE, wc*STRIDE) → ISSUE.
- ISSUE: pix_* are held stable while the datapath settles. At the clock edge, out_data <= max_pixel, out_valid <= 1, out_last <= (last window) → EMIT.
- EMIT:
  - out_valid, out_data, out_last and pix_* are held until out_valid&out_ready.
  - On handshake, if last window: clear out_valid and out_last, pulse done, → IDLE.
  - Otherwise: advance wc; on wc = OUT_W-1, wrap wc to 0 and increment wr. Then → SETUP.
- Last window is wr = OUT_H-1 and wc = OUT_W-1.
- Widths: counters are sized with $clog2 of their ranges, minimum 1 bit. No arithmetic is done on pixel data; the max is computed only by the external `downsample`.
- Trailing columns and rows not covered by a full window (stride remainder) are ignored.

## Timing
- Reset: state=IDLE; in_ready, out_valid, out_last, done and busy are 0; pix_* and out_data are 0; all counters are 0. Buffer contents are don't-care.
- Reset has priority over every other input, including mid-LOAD and mid-EMIT. The frame is abandoned with no done pulse and no further out_valid.
- Last input beat accepted in cycle t:
  - t+1: SETUP.
  - t+2: ISSUE, with pix_* valid.
  - t+3: EMIT, with out_valid=1.
- Output handshake in cycle t: next window's out_valid rises in t+3. Steady-state throughput with out_ready held high is 1 result per 3 cycles.
- done is high in the cycle after the final handshake. busy falls in that same cycle.
- out_valid never drops without a handshake; out_data is stable while out_valid&!out_ready.
- in_ready=0 in IDLE, SETUP, ISSUE and EMIT; input beats offered then are not consumed.

## Test plan
- Baseline: bench instantiates `downsample` on pix_*/max_pixel; defaults; start; stream 0,1,2,3,0,1,2,3,0 with out_ready=1 → out_data 3,2,3,3; out_last only on the 4th; done pulses once; out_valid rises 3 cycles after the 9th input beat.
- Backpressure: same frame, out_ready=0 for 5 cycles while the 2nd result (2) is valid → out_data=2 and pix_* = 1,2,0,1 hold stable; no window skipped; final sequence still 3,2,3,3.
- Input gaps and stray start: in_valid toggled 1/0 each cycle during LOAD; start pulsed during LOAD and EMIT → identical output sequence; no restart; exactly 9 beats consumed.
- Stride/size: IMG_W=IMG_H=4, STRIDE=2, pixels 0..15 → 4 outputs 5,7,13,15; window origins (0,0),(0,2),(2,0),(2,2); out_last on 15.
- Reset mid-frame: assert rst for 1 cycle while out_valid=1 on the 2nd result → next cycle all outputs 0 and state IDLE; no done; a new start plus full frame produces the correct full sequence.
- Boundary: IMG_W=IMG_H=2 with pixels 1,0,0,2 → single output 2 with out_last=1; done pulses the cycle after the handshake.
